// File: rtl/pending_prio_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pending_prio_encoder_pkg                                                     |
// | Shared index-width and one-hot helpers for the pending priority encoder.     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package pending_prio_encoder_pkg;

  localparam int unsigned c_max_n = 256;

  // Index width never drops below one bit, even for the smallest legal N.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic logic [c_max_n-1:0] onehot(input logic [7:0] idx,
                                                input int unsigned n);
    logic [c_max_n-1:0] r;
    r = '0;
    if (32'(idx) < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pending_prio_encoder_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prio_sel                                                                     |
// | Finds the highest set bit at or below start-1, wrapping modulo N.            |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module prio_sel #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int          pos;
  logic [W-1:0] pos_w;

  // Scan from farthest to nearest so the position just below start wins.
  always_comb begin
    found = |vec;
    idx   = '0;
    pos   = 0;
    pos_w = '0;
    for (int k = N; k >= 1; k--) begin
      pos   = (int'(start) + 2 * N - k) % N;
      pos_w = W'(pos);
      if (vec[pos_w]) idx = pos_w;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pending_prio_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pending_prio_encoder                                                         |
// | Sticky pending request bits presented through a valid/ready handshake.       |
// | Optional build macro ROUND_ROBIN_EN selects rotating instead of fixed prio.  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module pending_prio_encoder
  import pending_prio_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending
);

  typedef logic [W-1:0] idx_t;

  logic [N-1:0] r_pend;
  logic         r_valid;
  idx_t         r_idx;

  logic         w_acc;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_next;
  logic         w_found;
  idx_t         w_sel_idx;
  idx_t         w_start;

  assign w_acc       = r_valid & out_ready;
  assign w_clr       = w_acc ? N'(onehot(8'(r_idx), N)) : '0;
  // Re-request on the accepting edge keeps the bit pending.
  assign w_pend_next = (r_pend & ~w_clr) | req_in;

`ifdef ROUND_ROBIN_EN
  idx_t r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= '0;
    else if (w_acc) r_ptr <= r_idx;
  end

  // The grant loaded on an accepting edge already searches below the accepted index.
  assign w_start = w_acc ? r_idx : r_ptr;
`else
  assign w_start = '0;
`endif

  prio_sel #(
    .N (N),
    .W (W)
  ) u_prio_sel (
    .vec   (w_pend_next),
    .start (w_start),
    .found (w_found),
    .idx   (w_sel_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_next;
  end

  // Grant holds under backpressure; otherwise reloads with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (!r_valid || out_ready) begin
      r_valid <= w_found;
      r_idx   <= w_sel_idx;
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign pending   = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_pending_prio_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pending_prio_encoder                                                      |
// | Directed and randomized bench with a behavioural event-set reference model.  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_pending_prio_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;

  logic [3:0] req4;
  logic       ready4;
  logic       valid4;
  logic [1:0] idx4;
  logic [3:0] pend4;

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending events plus the presented grant.
  logic [7:0] m_pend;
  bit         m_valid;
  int         m_idx;
  int         m_ptr;

  always #5 clk = ~clk;

  pending_prio_encoder #(.N(8)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .pending(pending)
  );

  pending_prio_encoder #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .req_in(req4), .out_ready(ready4),
    .out_valid(valid4), .out_idx(idx4), .pending(pend4)
  );

  task automatic model_reset();
    m_pend = '0; m_valid = 0; m_idx = 0; m_ptr = 0;
  endtask

  task automatic model_edge(input logic [7:0] req, input bit rdy);
    bit acc;
    int start;
    bit found;
    int sel;
    acc = m_valid && rdy;
    if (acc) m_pend = m_pend & ~(8'd1 << m_idx);
    m_pend = m_pend | req;
    if (!m_valid || rdy) begin
`ifdef ROUND_ROBIN_EN
      start = acc ? m_idx : m_ptr;
      if (acc) m_ptr = m_idx;
`else
      start = 0;
`endif
      found = 0;
      sel   = 0;
      for (int k = 1; k <= 8; k++) begin
        int j;
        j = (start - k + 16) % 8;
        if (!found && m_pend[j]) begin
          found = 1;
          sel   = j;
        end
      end
      m_valid = found;
      m_idx   = sel;
    end
  endtask

  task automatic step(input logic [7:0] req, input bit rdy);
    req_in    = req;
    out_ready = rdy;
    @(posedge clk);
    model_edge(req, rdy);
    #1;
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL model_valid: got %0b expected %0b at %0t", out_valid, m_valid, $time);
    end
    checks++;
    if (out_idx !== 3'(m_idx)) begin
      errors++;
      $display("FAIL model_idx: got %0d expected %0d at %0t", out_idx, m_idx, $time);
    end
    checks++;
    if (pending !== m_pend) begin
      errors++;
      $display("FAIL model_pending: got %h expected %h at %0t", pending, m_pend, $time);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, out_idx, pending} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got v=%0b idx=%0d pend=%h expected all zero", out_valid, out_idx, pending);
    end
    checks++;
    if ({valid4, idx4, pend4} !== 7'h00) begin
      errors++;
      $display("FAIL reset_state_n4: got v=%0b idx=%0d pend=%h expected all zero", valid4, idx4, pend4);
    end
  endtask

  task automatic test_single_event();
    step(8'h20, 1);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
      errors++;
      $display("FAIL single_grant: got v=%0b idx=%0d expected v=1 idx=5", out_valid, out_idx);
    end
    step(8'h00, 1);
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL single_drain: got v=%0b pend=%h expected v=0 pend=00", out_valid, pending);
    end
  endtask

  task automatic test_multi_fixed();
    int exp_idx[3] = '{7, 5, 2};
    for (int i = 0; i < 3; i++) begin
      step(i == 0 ? 8'hA4 : 8'h00, 1);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'(exp_idx[i])) begin
        errors++;
        $display("FAIL multi_grant%0d: got v=%0b idx=%0d expected v=1 idx=%0d", i, out_valid, out_idx, exp_idx[i]);
      end
    end
    step(8'h00, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_end: got v=%0b expected v=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    step(8'h04, 0);
    step(8'h80, 0);
    step(8'h00, 0);
    checks++;
    if (out_idx !== 3'd2 || out_valid !== 1'b1 || pending !== 8'h84) begin
      errors++;
      $display("FAIL bp_hold: got v=%0b idx=%0d pend=%h expected v=1 idx=2 pend=84", out_valid, out_idx, pending);
    end
    step(8'h00, 1);
    checks++;
    if (out_idx !== 3'd7 || pending !== 8'h80) begin
      errors++;
      $display("FAIL bp_next: got idx=%0d pend=%h expected idx=7 pend=80", out_idx, pending);
    end
    step(8'h00, 1);
  endtask

  task automatic test_set_wins();
    step(8'h08, 1);
    step(8'h08, 1);
    checks++;
    if (pending[3] !== 1'b1 || out_valid !== 1'b1 || out_idx !== 3'd3) begin
      errors++;
      $display("FAIL set_wins: got pend=%h v=%0b idx=%0d expected pend[3]=1 v=1 idx=3", pending, out_valid, out_idx);
    end
    step(8'h00, 1);
  endtask

  task automatic test_round_robin();
`ifdef ROUND_ROBIN_EN
    int exp_seq[6] = '{3, 2, 1, 0, 3, 2};
`else
    int exp_seq[6] = '{3, 3, 3, 3, 3, 3};
`endif
    req4   = 4'hF;
    ready4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(8'h00, 1);
      checks++;
      if (valid4 !== 1'b1 || idx4 !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL rr_seq%0d: got v=%0b idx=%0d expected v=1 idx=%0d", i, valid4, idx4, exp_seq[i]);
      end
    end
    req4 = 4'h0;
    for (int i = 0; i < 5; i++) step(8'h00, 1);
    checks++;
    if (pend4 !== 4'h0 || valid4 !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: got v=%0b pend=%h expected v=0 pend=0", valid4, pend4);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    bit         rdy;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom % 3 == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      rdy = ($urandom % 4) != 0;
      step(r, rdy);
    end
    for (int i = 0; i < 10; i++) step(8'h00, 1);
  endtask

  task automatic test_async_reset();
    step(8'hFF, 0);
    #3;
    rst    = 1'b1;
    req_in = 8'hFF;
    #1;
    checks++;
    if ({out_valid, out_idx, pending} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got v=%0b idx=%0d pend=%h expected all zero", out_valid, out_idx, pending);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(8'h00, 1);
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL post_reset: got v=%0b pend=%h expected v=0 pend=00", out_valid, pending);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_in    = 8'hFF;
    out_ready = 1'b0;
    req4      = 4'h0;
    ready4    = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    req_in = 8'h00;
    test_reset();
    test_single_event();
    test_multi_fixed();
    test_backpressure();
    test_set_wins();
    test_round_robin();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
